// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement,
// block refill from instruction memory and whole-cache flush (fence.i).
module icache_assoc #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 read,
  input  logic [31:0]                          address,
  input  logic                                 flush,
  output logic [31:0]                          instruction,
  output logic                                 busywait,
  output logic                                 mem_read,
  output logic [32-2-$clog2(BLOCK_WORDS)-1:0]  mem_address,
  input  logic [32*BLOCK_WORDS-1:0]            mem_readdata,
  input  logic                                 mem_busywait
);

  localparam int OFF   = 2 + $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFF - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int WO_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int BLK_W = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0]    tags   [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    blocks [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid  [NUM_SETS];
  logic [NUM_WAYS-2:0] plru   [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WO_W-1:0]  woff;
  logic             unused;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             found;
  logic [BLK_W-1:0] hit_block;

  logic [WAY_W-1:0] lway;
  logic [IDX_W-1:0] lidx;
  logic [TAG_W-1:0] ltag;
  logic [BLK_W-1:0] lblock;
  logic             pend;

  assign idx    = address[OFF+IDX_W-1:OFF];
  assign tag    = address[31:OFF+IDX_W];
  assign unused = ^address[1:0];

  generate
    if (BLOCK_WORDS > 1) begin : g_woff
      assign woff = address[OFF-1:2];
    end else begin : g_woff_none
      assign woff = '0;
    end
  endgenerate

  // Tree bits point towards the victim side: 0 = left subtree, 1 = right subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      node = 2 * node + 32'(bits[node-1]);
    end
    return WAY_W'(node - NUM_WAYS);
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] nb;
    int unsigned         node;
    nb   = bits;
    node = 1;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      nb[node-1] = ~way[WAY_W-1-l];
      node       = 2 * node + 32'(way[WAY_W-1-l]);
    end
    return nb;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim = plru_victim(plru[idx]);
    found  = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

  assign hit_block = blocks[idx][hit_way];

  always_comb begin
    next_state  = state;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    instruction = '0;
    case (state)
      IDLE: begin
        if (read && hit) begin
          instruction = hit_block[32*int'(woff) +: 32];
        end else if (read) begin
          busywait   = 1'b1;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {ltag, lidx};
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && read && !hit) begin
      lway <= victim;
      lidx <= idx;
      ltag <= tag;
    end
    if (state == MEM_READ && !mem_busywait) lblock <= mem_readdata;
    if (state == UPDATE) begin
      tags[lidx][lway]   <= ltag;
      blocks[lidx][lway] <= lblock;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      state <= next_state;
      pend  <= (state == MEM_READ) ? (pend | flush) : 1'b0;
      case (state)
        IDLE:     if (read && hit) plru[idx] <= plru_touch(plru[idx], hit_way);
        UPDATE: begin
          valid[lidx][lway] <= 1'b1;
          plru[lidx]        <= plru_touch(plru[lidx], lway);
        end
        default: ;
      endcase
      // A flush seen during a refill is deferred so the new line is also dropped on IDLE entry.
      if ((state == IDLE && flush) || (state == UPDATE && (flush || pend))) begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
          valid[s] <= '0;
          plru[s]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (8 sets, 2 ways, 4-word blocks) against a
// latency-programmable instruction memory model.
module tb_icache_assoc;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [31:0]  address;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cnt   = 0;
  int refills = 0;
  int force_idle = 0;
  logic [31:0] exp_q[$];
  logic [27:0] last_maddr;
  int          last_stalls;

  icache_assoc #(.NUM_SETS(8), .NUM_WAYS(2), .BLOCK_WORDS(4)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address), .flush(flush),
    .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) * 32'h9E3779B9 + 32'h13579BDF;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_readdata[i*32 +: 32] = (force_idle != 0) ? (32'hDEAD0000 | 32'(i))
                                                   : word_at({mem_address, 4'h0} + 32'(i*4));
    end
    mem_busywait = (force_idle != 0) ? 1'b0 : (cnt < lat);
  end

  always @(posedge clock) begin
    if (reset || !mem_read) cnt <= 0;
    else                    cnt <= cnt + 1;
    if (!reset && mem_read && !mem_busywait) refills <= refills + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    flush = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that consumes the fetch.
  task automatic fetch(input logic [31:0] a, input int exp_stall, input int flush_at,
                       input string tag);
    int  stalls;
    logic seen;
    exp_q.push_back(word_at(a));
    read    = 1'b1;
    address = a;
    flush   = (flush_at == 0);
    stalls  = 0;
    seen    = 1'b0;
    last_maddr = '0;
    @(negedge clock);
    while (busywait && stalls < 200) begin
      stalls++;
      if (mem_read && !seen) begin
        last_maddr = mem_address;
        seen       = 1'b1;
      end
      flush = (stalls == flush_at);
      @(negedge clock);
    end
    last_stalls = stalls;
    check({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_data"}, instruction, exp_q.pop_front());
    @(posedge clock);
    #1;
    flush = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int r0;
    address = '0;
    do_reset();
    @(negedge clock);
    check("rst_busy", busywait, 0);
    check("rst_mread", mem_read, 0);
    check("rst_maddr", mem_address, 0);
    check("rst_instr", instruction, 0);
    @(posedge clock); #1;

    // 1: cold miss with 5 busy memory cycles, then hit on word 3
    lat = 5;
    fetch(32'h000, 8, -1, "t1_miss");
    check("t1_maddr", last_maddr, 28'h0);
    fetch(32'h00C, 0, -1, "t1_hit");

    // 2: LRU eviction in set 0
    do_reset();
    lat = 1;
    fetch(32'h000, 4, -1, "t2_a");
    fetch(32'h080, 4, -1, "t2_b");
    fetch(32'h000, 0, -1, "t2_a_hit");
    fetch(32'h100, 4, -1, "t2_c");
    fetch(32'h000, 0, -1, "t2_a_hit2");
    fetch(32'h080, 4, -1, "t2_b_evicted");
    check("t2_maddr", last_maddr, 28'h08);

    // 3: idle cycles change nothing
    repeat (10) begin
      @(negedge clock);
      check("t3_busy", busywait, 0);
      check("t3_mread", mem_read, 0);
    end
    @(posedge clock); #1;
    fetch(32'h000, 0, -1, "t3_a_hit");
    fetch(32'h084, 0, -1, "t3_b_hit");

    // 4: flush in IDLE and during a refill
    do_reset();
    lat = 1;
    fetch(32'h000, 4, -1, "t4_fill");
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    fetch(32'h000, 4, -1, "t4_after_flush");
    r0 = refills;
    fetch(32'h040, 8, 2, "t4_midflush");
    check("t4_refills", 64'(refills - r0), 2);
    fetch(32'h044, 0, 0, "t4_hit_with_flush");
    fetch(32'h048, 4, -1, "t4_post_flush");

    // 5: reset during MEM_READ aborts the refill
    do_reset();
    lat = 10;
    read = 1'b1;
    address = 32'h000;
    repeat (3) @(negedge clock);
    check("t5_mread_before", mem_read, 1);
    reset = 1'b1;
    read  = 1'b0;
    @(negedge clock);
    check("t5_mread_after", mem_read, 0);
    check("t5_busy_after", busywait, 0);
    reset = 1'b0;
    force_idle = 1;
    repeat (3) begin
      @(negedge clock);
      check("t5_mread_idle", mem_read, 0);
    end
    @(posedge clock); #1;
    force_idle = 0;
    lat = 2;
    fetch(32'h000, 5, -1, "t5_refetch");

    // 6: sequential sweep over 1 KiB
    do_reset();
    lat = 2;
    r0 = refills;
    for (int a = 0; a < 1024; a += 4) begin
      fetch(32'(a), ((a % 16) == 0) ? 5 : 0, -1, "t6_seq");
    end
    check("t6_refills", 64'(refills - r0), 64);
    check("t6_queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
